// File: rtl/ref_ramp_gen.sv
// ref_ramp_gen
//
// Rate-limited setpoint generator that sits between the reference selector
// and the servo position controller. It samples the signed reference from the
// constant memory and walks Setpoint toward it. Each tick moves Setpoint by at
// most STEP. Each new Setpoint is offered over a valid/ready handshake. While
// the controller has not accepted a value, Setpoint is held and ticks are
// dropped.
//
// Optional feature macro: REF_CLAMP_EN
//   defined   - the captured target is saturated to [-LIMIT, +LIMIT]
//   undefined - the reference is used as-is and LIMIT is ignored
//
// Ports:
//   CLK_G      in   system clock
//   reset_G    in   asynchronous, active-high reset
//   En         in   enable for the tick counter and the target capture
//   Ref_in     in   signed reference, cant_bits wide
//   sp_ready   in   the controller accepts the offered setpoint
//   Setpoint   out  ramped setpoint, registered, signed
//   sp_valid   out  Setpoint holds a new value that has not been accepted
//   busy       out  the FSM is not idle (registered)
//   at_target  out  Setpoint equals the captured target (registered)

module ref_ramp_gen #(
    parameter int                          cant_bits = 16,
    parameter int                          STEP      = 16,
    parameter int                          TICK_DIV  = 50000,
    parameter logic signed [cant_bits-1:0] LIMIT     = 16'sd8000
) (
    input  logic                        CLK_G,
    input  logic                        reset_G,
    input  logic                        En,
    input  logic signed [cant_bits-1:0] Ref_in,
    input  logic                        sp_ready,
    output logic signed [cant_bits-1:0] Setpoint,
    output logic                        sp_valid,
    output logic                        busy,
    output logic                        at_target
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

    state_t                      state_reg, state_next;
    logic [CW-1:0]               cnt_reg, cnt_next;
    logic signed [cant_bits-1:0] target_reg, target_next;
    logic signed [cant_bits-1:0] setpoint_reg, setpoint_next;
    logic signed [cant_bits-1:0] ref_sat;
    logic                        sp_valid_reg, valid_next;
    logic                        busy_reg, at_target_reg;
    logic                        tick;

    // The difference is computed one bit wider so that a full-scale swing
    // cannot wrap. Because of the clipping below, every result stays between
    // the old Setpoint and the target.
    logic signed [cant_bits:0]   diff, diff_mag, sp_ext, step_ext;

    // Reference conditioning.
`ifdef REF_CLAMP_EN
    always_comb begin
        ref_sat = Ref_in;
        if (Ref_in > LIMIT)
            ref_sat = LIMIT;
        else if (Ref_in < -LIMIT)
            ref_sat = -LIMIT;
    end
`else
    assign ref_sat = Ref_in;
`endif

    // LIMIT only matters when clamping is built in.
    logic limit_unused;
    assign limit_unused = ^LIMIT;

    // Target capture and tick counter. Both freeze while En is low.
    assign target_next = En ? ref_sat : target_reg;
    assign tick        = En && (cnt_reg == TICK_LAST);

    always_comb begin
        cnt_next = cnt_reg;
        if (En)
            cnt_next = (cnt_reg == TICK_LAST) ? '0 : cnt_reg + 1'b1;
    end

    // Ramp arithmetic.
    assign sp_ext   = (cant_bits+1)'(setpoint_reg);
    assign step_ext = (cant_bits+1)'(STEP);
    assign diff     = (cant_bits+1)'(target_reg) - sp_ext;
    assign diff_mag = diff[cant_bits] ? -diff : diff;

    // Next-state and datapath decisions.
    always_comb begin
        state_next    = state_reg;
        setpoint_next = setpoint_reg;
        valid_next    = sp_valid_reg;
        case (state_reg)
            IDLE: begin
                if (target_reg != setpoint_reg)
                    state_next = RAMP;
            end
            RAMP: begin
                if (tick) begin
                    if (diff == '0) begin
                        // The target moved back onto Setpoint, so nothing is offered.
                        state_next = IDLE;
                    end else begin
                        if (diff_mag <= step_ext)
                            setpoint_next = target_reg;
                        else if (!diff[cant_bits])
                            setpoint_next = cant_bits'(sp_ext + step_ext);
                        else
                            setpoint_next = cant_bits'(sp_ext - step_ext);
                        valid_next = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                // This completes whatever En is, so a disabled block can still
                // hand off the value it has already produced.
                if (sp_valid_reg && sp_ready) begin
                    valid_next = 1'b0;
                    state_next = (setpoint_reg == target_reg) ? IDLE : RAMP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_G or posedge reset_G) begin
        if (reset_G) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            target_reg    <= '0;
            setpoint_reg  <= '0;
            sp_valid_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            at_target_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            target_reg    <= target_next;
            setpoint_reg  <= setpoint_next;
            sp_valid_reg  <= valid_next;
            busy_reg      <= (state_next != IDLE);
            at_target_reg <= (setpoint_next == target_next);
        end
    end

    assign Setpoint  = setpoint_reg;
    assign sp_valid  = sp_valid_reg;
    assign busy      = busy_reg;
    assign at_target = at_target_reg;

endmodule

// File: tb/tb_ref_ramp_gen.sv
// Testbench for ref_ramp_gen. It uses two instances, both with TICK_DIV=4.
// The small-step instance (STEP=16) covers reset, ramping, back-pressure and
// enable gating. The large-step instance (STEP=30000) covers full-scale swings.
// Expected setpoints are queued when the stimulus is driven. They are popped
// on each accepted handshake.
module tb_ref_ramp_gen;

    logic clk = 1'b0;
    logic rst;
    logic en, sp_ready;
    logic signed [15:0] ref_in;
    logic signed [15:0] setpoint;
    logic sp_valid, busy, at_target;

    logic en_b, ready_b;
    logic signed [15:0] ref_b;
    logic signed [15:0] setpoint_b;
    logic valid_b, busy_b, at_target_b;

    logic signed [15:0] q_a[$];
    logic signed [15:0] q_b[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ref_ramp_gen #(.cant_bits(16), .STEP(16), .TICK_DIV(4), .LIMIT(16'sd8000)) dut (
        .CLK_G(clk), .reset_G(rst), .En(en), .Ref_in(ref_in), .sp_ready(sp_ready),
        .Setpoint(setpoint), .sp_valid(sp_valid), .busy(busy), .at_target(at_target)
    );

    ref_ramp_gen #(.cant_bits(16), .STEP(30000), .TICK_DIV(4), .LIMIT(16'sd8000)) dut_big (
        .CLK_G(clk), .reset_G(rst), .En(en_b), .Ref_in(ref_b), .sp_ready(ready_b),
        .Setpoint(setpoint_b), .sp_valid(valid_b), .busy(busy_b), .at_target(at_target_b)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Pop one expected value per accepted handshake, with a bounded wait.
    task automatic drain(input string tag, input bit big, input int n);
        int got = 0;
        int cyc = 0;
        logic signed [15:0] expv;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (big ? (valid_b && ready_b) : (sp_valid && sp_ready)) begin
                if (big ? (q_b.size() == 0) : (q_a.size() == 0)) begin
                    chk({tag, "_unexpected"}, big ? setpoint_b : setpoint, 32'sh7fffffff);
                end else begin
                    expv = big ? q_b.pop_front() : q_a.pop_front();
                    chk(tag, big ? setpoint_b : setpoint, expv);
                    $display("%s: setpoint %0d accepted", tag, big ? setpoint_b : setpoint);
                end
                got++;
            end
        end
        chk({tag, "_count"}, got, n);
    endtask

    // Edges from now until sp_valid rises on the small instance.
    task automatic latency(input string tag, input int expected);
        int cyc = 0;
        while (!sp_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk(tag, cyc, expected);
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; sp_ready = 1'b1; ref_in = '0;
        en_b = 1'b1; ready_b = 1'b1; ref_b = '0;

        // 1: an asynchronous reset before any clock edge takes effect at once.
        #2 rst = 1'b1;
        #1;
        chk("rst_setpoint", setpoint, 0);
        chk("rst_valid", sp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_at_target", at_target, 1);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // 2: ramp up from 0 to 40.
        ref_in = 16'sd40;
        q_a.push_back(16'sd16); q_a.push_back(16'sd32); q_a.push_back(16'sd40);
        drain("up40", 1'b0, 3);
        repeat (3) @(posedge clk);
        #1;
        chk("up40_at_target", at_target, 1);
        chk("up40_busy", busy, 0);
        chk("up40_final", setpoint, 40);

        // 3: ramp down from 40 to -20.
        @(posedge clk); #1 ref_in = -16'sd20;
        q_a.push_back(16'sd24); q_a.push_back(16'sd8);
        q_a.push_back(-16'sd8); q_a.push_back(-16'sd20);
        drain("dn20", 1'b0, 4);
        repeat (3) @(posedge clk);
        #1;
        chk("dn20_at_target", at_target, 1);
        chk("dn20_busy", busy, 0);

        // 4: a reset in the middle of a ramp, then back-pressure.
        ref_in = 16'sd1000;
        repeat (6) @(posedge clk);
        #3 rst = 1'b1; ref_in = 16'sd40; sp_ready = 1'b0;
        #1;
        chk("midrst_setpoint", setpoint, 0);
        chk("midrst_valid", sp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_at_target", at_target, 1);
        @(posedge clk); #1 rst = 1'b0;
        latency("rst_latency", 4);
        chk("bp_first", setpoint, 16);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_valid_held", sp_valid, 1);
        chk("bp_setpoint_held", setpoint, 16);
        sp_ready = 1'b1;
        q_a.push_back(16'sd16); q_a.push_back(16'sd32); q_a.push_back(16'sd40);
        drain("bp", 1'b0, 3);

        // 5: En gating at Setpoint 32.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; ref_in = 16'sd40; en = 1'b1;
        q_a.push_back(16'sd16); q_a.push_back(16'sd32);
        drain("en", 1'b0, 2);
        @(posedge clk); #1 en = 1'b0; ref_in = 16'sd32;
        repeat (21) @(posedge clk);
        #1;
        chk("en_off_setpoint", setpoint, 32);
        chk("en_off_valid", sp_valid, 0);
        chk("en_off_busy", busy, 1);
        chk("en_off_at_target", at_target, 0);
        en = 1'b1; ref_in = 16'sd40;
        q_a.push_back(16'sd40);
        latency("en_resume_latency", 3);
        drain("en_resume", 1'b0, 1);

        // 6: a full-scale swing on the large-step instance.
        @(posedge clk); #1 ref_b = -16'sd32768;
`ifdef REF_CLAMP_EN
        q_b.push_back(-16'sd8000);
        drain("big_neg", 1'b1, 1);
`else
        q_b.push_back(-16'sd30000); q_b.push_back(-16'sd32768);
        drain("big_neg", 1'b1, 2);
`endif
        @(posedge clk); #1 ref_b = 16'sd32767;
`ifdef REF_CLAMP_EN
        q_b.push_back(16'sd8000);
        drain("big_pos", 1'b1, 1);
`else
        q_b.push_back(-16'sd2768); q_b.push_back(16'sd27232); q_b.push_back(16'sd32767);
        drain("big_pos", 1'b1, 3);
`endif
        repeat (3) @(posedge clk);
        #1;
`ifdef REF_CLAMP_EN
        chk("big_final", setpoint_b, 8000);
`else
        chk("big_final", setpoint_b, 32767);
`endif
        chk("big_at_target", at_target_b, 1);
        chk("big_busy", busy_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ref_ramp_gen.md
Name: ref_ramp_gen

Overview:
Consumer end of the switch-selected reference path. Samples the signed reference constant chosen by the switch/constant-memory selector and ramps a servo setpoint toward it at a bounded rate. Each setpoint update is offered to the position controller over a valid/ready handshake. Sits between the reference selector and the servo control loop.

Parameters:
cant_bits, 16, width of reference and setpoint (signed, two's complement)
STEP, 16, maximum setpoint change per update (positive, < 2^(cant_bits-1))
TICK_DIV, 50000, clock cycles between ramp updates (>= 2)
LIMIT, 16'sd8000, clamp magnitude (used only with REF_CLAMP_EN)

Ports:
CLK_G  in  1  system clock
reset_G  in  1  asynchronous, active-high reset
En  in  1  enable: gates tick counter and target capture
Ref_in  in  cant_bits  signed reference from constant memory
sp_ready  in  1  controller accepts setpoint
Setpoint  out  cant_bits  signed ramped setpoint (registered)
sp_valid  out  1  Setpoint holds a new, unaccepted value
busy  out  1  FSM not in IDLE
at_target  out  1  Setpoint == captured target (registered)

Behaviour:
- Reset (async, immediate): Setpoint=0, target_q=0, tick counter=0, FSM=IDLE, sp_valid=0, busy=0, at_target=1.
- Target capture: target_q <= Ref_in on each clock while En=1. With En=0, target_q holds.
- Tick counter: counts 0..TICK_DIV-1 while En=1, wraps to 0. tick is 1 for the single cycle with count==TICK_DIV-1 and En=1. With En=0 the counter holds.
- FSM states:
  - IDLE: if target_q != Setpoint, go to RAMP on the next edge.
  - RAMP: on a tick, compute diff = target_q - Setpoint in cant_bits+1 bits.
    - If |diff| <= STEP: Setpoint <= target_q.
    - Else: Setpoint <= Setpoint + STEP when diff > 0, or Setpoint - STEP when diff < 0.
    - On the same edge set sp_valid=1 and go to HOLD.
    - If diff==0 on a tick (target moved back to Setpoint), go to IDLE with no update.
  - HOLD: hold sp_valid=1 and keep Setpoint stable until a cycle with sp_valid && sp_ready. On that edge clear sp_valid, then:
    - go to IDLE if Setpoint == target_q (as sampled that cycle);
    - otherwise go to RAMP.
- Ticks arriving in HOLD or IDLE are dropped, not queued.
- The handshake completes regardless of En.
- Arithmetic: no wrap-around. Because the last step is clipped to diff, Setpoint always stays within the target range. A full-scale swing (-32768 to 32767) must be correct.
- Target changes mid-ramp: the new target applies at the next update; direction may reverse.
- Latency: the first update occurs on the first tick after entering RAMP, within TICK_DIV+1 cycles of a target change.
- busy = (FSM != IDLE), registered.
- at_target is updated every cycle from next-state values.
- Reset mid-ramp or mid-handshake: all state clears at once; a pending sp_valid drops without acceptance.

Optional Feature:
REF_CLAMP_EN
- Defined: target_q <= Ref_in saturated to [-LIMIT, +LIMIT]. at_target compares against the clamped value.
- Undefined: no clamping; LIMIT is unused.

Test Plan:
1. reset_G pulse mid-clock -> immediately Setpoint=0, sp_valid=0, busy=0, at_target=1. Counter restarts from 0.
2. TICK_DIV=4, STEP=16, sp_ready=1, Ref_in 0->40 -> Setpoint 16, 32, 40 on successive ticks. Each update gives a 1-cycle sp_valid. Then at_target=1 and busy=0.
3. From 40, Ref_in=-20 -> Setpoint 24, 8, -8, -20, then IDLE.
4. sp_ready=0 for 10 cycles after the first update to 16 -> Setpoint stays 16 and sp_valid stays 1 with ticks dropped. After sp_ready=1, the next update (32) lands on a tick after acceptance.
5. En=0 during a ramp at Setpoint=32 -> no further updates, counter frozen. Re-asserting En resumes the ramp toward target.
6. STEP=30000, Ref_in=32767 from -32768:
   - without REF_CLAMP_EN -> Setpoint -2768, 27232, 32767, with no overflow;
   - with REF_CLAMP_EN and LIMIT=8000 -> final Setpoint 8000.
